// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO, a status/control
// register and a level transmit-done interrupt; rdata is zero when not selected.
module uart_tx_responder #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] TXD_ADDR     = 32'h40000018,
    parameter logic [31:0] CON_ADDR     = 32'h40000020,
    parameter int          FIFO_LOG2    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        UART_TX,
    output logic        tx_irq
);

    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef logic [FIFO_LOG2:0] ptr_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam ptr_t              FULL_CNT  = ptr_t'(DEPTH);

    state_t            r_state;
    state_t            w_nextState;
    logic [BAUD_W-1:0] r_baudCnt;
    logic [BAUD_W-1:0] w_nextBaudCnt;
    logic [2:0]        r_bitIdx;
    logic [2:0]        w_nextBitIdx;
    logic [7:0]        r_shift;
    logic [7:0]        w_nextShift;
    logic              r_tx;
    logic              w_txNext;
    logic              w_pop;
    logic              w_setDone;
    logic              w_baudEnd;

    logic [7:0]        r_mem [DEPTH];
    ptr_t              r_wptr;
    ptr_t              r_rptr;
    ptr_t              w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_busy;
    logic [7:0]        w_head;
    logic              w_push;
    logic              w_setOvf;

    logic              w_txdWrite;
    logic              w_txdRead;
    logic              w_conWrite;
    logic              w_conRead;

    logic              r_done;
    logic              r_overflow;
    logic              r_irqEn;
    logic              r_irq;
    logic [7:0]        r_lastByte;

    logic              w_unused;

    assign w_txdWrite = wr && (addr == TXD_ADDR);
    assign w_txdRead  = rd && (addr == TXD_ADDR);
    assign w_conWrite = wr && (addr == CON_ADDR);
    assign w_conRead  = rd && (addr == CON_ADDR);

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (w_count == FULL_CNT);
    assign w_head    = r_mem[r_rptr[FIFO_LOG2-1:0]];
    assign w_busy    = (r_state != S_IDLE) || !w_empty;
    assign w_baudEnd = (r_baudCnt == BAUD_LAST);

    // A pop at the same edge frees the slot, so a write to a full FIFO still lands.
    assign w_push   = w_txdWrite && (!w_full || w_pop);
    assign w_setOvf = w_txdWrite && w_full && !w_pop;

    assign w_unused = ^wdata[31:8];

    always_comb begin
        w_nextState   = r_state;
        w_nextBaudCnt = r_baudCnt;
        w_nextBitIdx  = r_bitIdx;
        w_nextShift   = r_shift;
        w_txNext      = 1'b1;
        w_pop         = 1'b0;
        w_setDone     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_nextShift   = w_head;
                    w_nextBaudCnt = '0;
                    w_nextState   = S_START;
                    w_txNext      = 1'b0;
                end
            end
            S_START: begin
                w_txNext = 1'b0;
                if (w_baudEnd) begin
                    w_nextState   = S_DATA;
                    w_nextBaudCnt = '0;
                    w_nextBitIdx  = '0;
                    w_txNext      = r_shift[0];
                end else begin
                    w_nextBaudCnt = r_baudCnt + 1'b1;
                end
            end
            S_DATA: begin
                w_txNext = r_shift[0];
                if (w_baudEnd) begin
                    w_nextBaudCnt = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = S_STOP;
                        w_txNext    = 1'b1;
                    end else begin
                        w_nextBitIdx = r_bitIdx + 1'b1;
                        w_nextShift  = {1'b0, r_shift[7:1]};
                        w_txNext     = r_shift[1];
                    end
                end else begin
                    w_nextBaudCnt = r_baudCnt + 1'b1;
                end
            end
            S_STOP: begin
                w_txNext = 1'b1;
                if (w_baudEnd) begin
                    w_setDone     = 1'b1;
                    w_nextBaudCnt = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextShift = w_head;
                        w_nextState = S_START;
                        w_txNext    = 1'b0;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else begin
                    w_nextBaudCnt = r_baudCnt + 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_baudCnt <= w_nextBaudCnt;
            r_bitIdx  <= w_nextBitIdx;
            r_shift   <= w_nextShift;
            r_tx      <= w_txNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_LOG2-1:0]] <= wdata[7:0];
        end
    end

    // Sticky flags clear on a CON read; a coincident set event takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_irqEn    <= 1'b0;
            r_irq      <= 1'b0;
            r_lastByte <= '0;
        end else begin
            if (w_setDone) begin
                r_done <= 1'b1;
            end else if (w_conRead) begin
                r_done <= 1'b0;
            end
            if (w_setOvf) begin
                r_overflow <= 1'b1;
            end else if (w_conRead) begin
                r_overflow <= 1'b0;
            end
            if (w_conWrite) begin
                r_irqEn <= wdata[3];
            end
            if (w_txdWrite) begin
                r_lastByte <= wdata[7:0];
            end
            r_irq <= r_done & r_irqEn;
        end
    end

    always_comb begin
        rdata = 32'b0;
        if (w_conRead) begin
            rdata = {27'b0, r_overflow, r_irqEn, r_done, w_full, w_busy};
        end else if (w_txdRead) begin
            rdata = {24'b0, r_lastByte};
        end
    end

    assign UART_TX = r_tx;
    assign tx_irq  = r_irq;

endmodule

// File: doc/uart_tx_responder.md
Name: uart_tx_responder

Overview:
- Memory-mapped UART transmitter that answers CPU loads and stores on the peripheral bus (address ≥ 0x40000000 region).
- Accepts bytes written by the processor into a small TX FIFO and serialises them 8N1 on UART_TX.
- Exposes a status/control register and a transmit-done interrupt line feeding the processor's interrupt logic.
- rdata is zero when the block is not selected, so it can be OR-combined with other read-data sources.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit; legal range ≥2.
- TXD_ADDR, 32'h40000018, byte-write data register address.
- CON_ADDR, 32'h40000020, status/control register address.
- FIFO_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  input  1  single clock; all state on posedge clk.
- reset  input  1  asynchronous, active-low reset (negedge reset clears all state).
- rd  input  1  bus read strobe.
- wr  input  1  bus write strobe.
- addr  input  32  bus byte address.
- wdata  input  32  bus write data.
- rdata  output  32  bus read data; combinational.
- UART_TX  output  1  serial line; registered; idles high.
- tx_irq  output  1  registered interrupt request, level.

Behaviour:
- Reset values: UART_TX=1, tx_irq=0, FIFO empty, FSM=IDLE, all flags 0, irq_en=0. rdata is combinational and therefore 0 under reset.
- Reset mid-frame: UART_TX returns to 1 immediately; queued bytes are discarded.
- CON read value: {27'b0, overflow, irq_en, done, full, busy}.
  - busy: FSM≠IDLE or FIFO non-empty.
  - full: FIFO count = 2^FIFO_LOG2.
- rdata output:
  - rd & addr==CON_ADDR: the CON read value.
  - rd & addr==TXD_ADDR: {24'b0, last byte written}.
  - Otherwise: 32'b0.
- Write to TXD_ADDR (wr sampled at edge k):
  - Pushes wdata[7:0] if not full.
  - If full and no pop at the same edge: byte dropped, overflow set.
  - Push and pop at the same edge with FIFO full: push accepted, no overflow.
- Write to CON_ADDR: irq_en ← wdata[3]. All other bits are read-only.
- Any read of CON_ADDR clears done and overflow at that edge. If a set event coincides with the clear, set wins.
- Writes and reads to other addresses: ignored.
- FSM states: IDLE, START, DATA, STOP.
  - bit counter: 3 bits; baud counter: counts 0..CLKS_PER_BIT-1.
- IDLE: UART_TX=1. When FIFO non-empty, pop into shift register → START; UART_TX=0 from the next edge.
  - Latency: a write at edge k drives UART_TX low after edge k+1.
- START: hold UART_TX=0 for CLKS_PER_BIT cycles → DATA.
- DATA: send shift[0] LSB first, each bit for CLKS_PER_BIT cycles; after bit 7 → STOP.
- STOP: UART_TX=1 for CLKS_PER_BIT cycles, then set done.
  - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle cycles).
  - FIFO empty: → IDLE.
- Frame length: exactly 10·CLKS_PER_BIT cycles.
- tx_irq: registered (done & irq_en); asserts one cycle after done is set and stays high until a CON read clears done.
- FIFO pointers are FIFO_LOG2+1 bits and wrap modulo 2^(FIFO_LOG2+1); bytes leave in write order.

Test Plan:
- Single byte, CLKS_PER_BIT=4: write 0x55 to TXD_ADDR at edge k.
  - UART_TX low after edge k+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - CON reads 0x04 afterwards; a second CON read returns 0x00.
- Back-to-back: write 0xA5 and 0x3C on consecutive cycles.
  - Two frames totalling 80 cycles with no gap between the stop bit and the next start bit; busy=1 throughout, 0 after.
- Overflow: write 0x01..0x06 on 6 consecutive cycles.
  - 0x01..0x05 transmitted in order; 0x06 dropped.
  - CON bit4=1, bit1=1 while the FIFO holds 4 bytes.
- Interrupt: write CON=0x08, then send 0x00.
  - tx_irq rises one cycle after the stop bit completes.
  - A CON read returns 0x0C; tx_irq falls on the following cycle.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - UART_TX=1 immediately, tx_irq=0, CON=0x00 after release; no further frames.
- Decode isolation: rd at 0x40000010 and 0x00000018.
  - rdata=0 both times; wr at those addresses leaves the FIFO empty and UART_TX=1.
